fetch_sequencer: RTL and testbench

//  Sequential half of the CPU core: holds the FSM state register, program counter (PC)
//  and instruction register (IR) that the combinational control unit reads from.

---
 rtl/fetch_sequencer.sv | 107 ++++++++++
 tb/tb_fetch_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Sequential half of the CPU core: FSM state, PC and IR registers, a sticky halt
// flag and a saturating retired-instruction counter, driven by the control unit.
module fetch_sequencer #(
    parameter int                  PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           next_state,
    input  logic                 pc_we,
    input  logic                 pc_sel,
    input  logic                 pc_jmp_sel,
    input  logic [3:0]           pc_offset,
    input  logic                 ir_we,
    input  logic                 halt,
    input  logic [7:0]           mem_rdata,
    output logic [2:0]           state,
    output logic [7:0]           instr,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH      = 3'b000,
        DECODE     = 3'b001,
        EXECUTE    = 3'b010,
        MEMORY     = 3'b011,
        WRITEBACK  = 3'b100,
        HALT_STATE = 3'b101
    } state_e;

    // No valid/ready handshake: every enable from the control unit is a
    // single-cycle strobe sampled at the rising edge it is high for.
    logic [2:0]           r_state;
    logic [7:0]           r_instr;
    logic [PC_WIDTH-1:0]  r_pc;
    logic                 r_halted;
    logic [CNT_WIDTH-1:0] r_retired;

    logic [2:0]           w_state_nxt;
    logic [7:0]           w_instr_nxt;
    logic [PC_WIDTH-1:0]  w_pc_nxt;
    logic                 w_halted_nxt;
    logic [CNT_WIDTH-1:0] w_retired_nxt;
    logic [PC_WIDTH-1:0]  w_pc_inc;
    logic [PC_WIDTH-1:0]  w_pc_rel;
    logic [PC_WIDTH-1:0]  w_pc_abs;

    assign w_pc_inc = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign w_pc_rel = r_pc + {{(PC_WIDTH-4){pc_offset[3]}}, pc_offset};
    assign w_pc_abs = {r_pc[PC_WIDTH-1:4], pc_offset};

    always_comb begin
        w_state_nxt   = r_state;
        w_instr_nxt   = r_instr;
        w_pc_nxt      = r_pc;
        w_halted_nxt  = r_halted;
        w_retired_nxt = r_retired;
        if (!r_halted) begin
            if (halt) begin
                // Halting edge suppresses the PC/IR writes that accompany it.
                w_halted_nxt = 1'b1;
                w_state_nxt  = HALT_STATE;
            end else begin
                w_state_nxt = next_state;
                if (pc_we) begin
                    if (!pc_sel)
                        w_pc_nxt = w_pc_inc;
                    else if (!pc_jmp_sel)
                        w_pc_nxt = w_pc_rel;
                    else
                        w_pc_nxt = w_pc_abs;
                end
                if (ir_we) begin
                    w_instr_nxt = mem_rdata;
                    if (r_retired != {CNT_WIDTH{1'b1}})
                        w_retired_nxt = r_retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= FETCH;
            r_instr   <= 8'h00;
            r_pc      <= RESET_PC;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_instr   <= w_instr_nxt;
            r_pc      <= w_pc_nxt;
            r_halted  <= w_halted_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    assign state   = r_state;
    assign instr   = r_instr;
    assign pc      = r_pc;
    assign halted  = r_halted;
    assign retired = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer against a behavioural model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  next_state = '0;
    logic        pc_we = 1'b0;
    logic        pc_sel = 1'b0;
    logic        pc_jmp_sel = 1'b0;
    logic [3:0]  pc_offset = '0;
    logic        ir_we = 1'b0;
    logic        halt = 1'b0;
    logic [7:0]  mem_rdata;
    logic [2:0]  state;
    logic [7:0]  instr;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] retired;

    logic [7:0]  mem [256];
    logic [35:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    int m_state, m_pc, m_instr, m_halted, m_retired;

    fetch_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .next_state(next_state), .pc_we(pc_we),
        .pc_sel(pc_sel), .pc_jmp_sel(pc_jmp_sel), .pc_offset(pc_offset),
        .ir_we(ir_we), .halt(halt), .mem_rdata(mem_rdata), .state(state),
        .instr(instr), .pc(pc), .halted(halted), .retired(retired)
    );

    assign mem_rdata = mem[pc];

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".state"},   16'(state),   16'(m_state));
        chk({tag, ".instr"},   16'(instr),   16'(m_instr));
        chk({tag, ".pc"},      16'(pc),      16'(m_pc));
        chk({tag, ".halted"},  16'(halted),  16'(m_halted));
        chk({tag, ".retired"}, retired,      16'(m_retired));
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_instr = 0; m_halted = 0; m_retired = 0;
    endtask

    // Architectural rules applied with plain integer arithmetic.
    task automatic model_step(input int ns, input int we, input int sel, input int jsel,
                              input int off, input int irw, input int h);
        int old_pc;
        if (m_halted != 0) return;
        if (h != 0) begin
            m_halted = 1;
            m_state  = 5;
            return;
        end
        old_pc  = m_pc;
        m_state = ns;
        if (irw != 0) begin
            m_instr = int'(mem[old_pc]);
            if (m_retired < 65535) m_retired = m_retired + 1;
        end
        if (we != 0) begin
            if (sel == 0)       m_pc = (old_pc + 1) % 256;
            else if (jsel == 0) m_pc = (old_pc + ((off >= 8) ? off - 16 : off) + 256) % 256;
            else                m_pc = (old_pc / 16) * 16 + off;
        end
    endtask

    task automatic idle_inputs();
        next_state = '0; pc_we = 1'b0; pc_sel = 1'b0; pc_jmp_sel = 1'b0;
        pc_offset = '0; ir_we = 1'b0; halt = 1'b0;
    endtask

    task automatic step(input int ns, input int we, input int sel, input int jsel,
                        input int off, input int irw, input int h);
        @(negedge clk);
        next_state = 3'(ns); pc_we = 1'(we); pc_sel = 1'(sel); pc_jmp_sel = 1'(jsel);
        pc_offset = 4'(off); ir_we = 1'(irw); halt = 1'(h);
        model_step(ns, we, sel, jsel, off, irw, h);
        exp_q.push_back({3'(m_state), 8'(m_instr), 8'(m_pc), 1'(m_halted), 16'(m_retired)});
    endtask

    task automatic rand_step(input int allow_halt);
        step($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
             (allow_halt != 0) ? $urandom_range(0, 1) : 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_all(tag);
        idle_inputs();
        #1;
        reset = 1'b0;
    endtask

    // Monitor: pops one expected snapshot per edge that had stimulus behind it.
    initial begin
        logic [35:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb.state",   16'(state),  16'(e[35:33]));
                chk("sb.instr",   16'(instr),  16'(e[32:25]));
                chk("sb.pc",      16'(pc),     16'(e[24:17]));
                chk("sb.halted",  16'(halted), 16'(e[16]));
                chk("sb.retired", retired,     e[15:0]);
            end
        end
    end

    initial begin
        int saved_pc, saved_instr, saved_ret;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[4] = 8'hA5;
        model_reset();

        // Reset held with inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            next_state = 3'($urandom_range(0, 7)); pc_we = 1'($urandom_range(0, 1));
            pc_sel = 1'($urandom_range(0, 1)); pc_jmp_sel = 1'($urandom_range(0, 1));
            pc_offset = 4'($urandom_range(0, 15)); ir_we = 1'($urandom_range(0, 1));
            halt = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk_all("rst_hold");
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;

        // Random traffic, then asynchronous reset between edges.
        for (int i = 0; i < 300; i++) rand_step(0);
        settle();
        async_reset("rst_async");

        // Wrap FF->00 and hold when pc_we=0.
        step(1, 1, 1, 0, 15, 0, 0);
        settle(); chk("pc_to_ff", 16'(pc), 16'h00FF);
        step(2, 1, 0, 0, 0, 0, 0);
        settle(); chk("pc_wrap", 16'(pc), 16'h0000);
        step(3, 0, 1, 1, 9, 0, 0);
        settle(); chk("pc_hold", 16'(pc), 16'h0000);

        // Relative and absolute jumps.
        step(0, 1, 1, 1, 15, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        settle(); chk("pc_10", 16'(pc), 16'h0010);
        step(1, 1, 1, 0, 14, 0, 0);
        settle(); chk("pc_rel_neg", 16'(pc), 16'h000E);
        step(2, 1, 1, 1, 7, 0, 0);
        settle(); chk("pc_abs_07", 16'(pc), 16'h0007);

        // Same-edge IR load and PC increment.
        step(0, 1, 1, 1, 4, 0, 0);
        step(1, 1, 0, 0, 0, 1, 0);
        settle();
        chk("ir_a5", 16'(instr), 16'h00A5);
        chk("pc_05", 16'(pc), 16'h0005);
        chk("ret_1", retired, 16'h0001);

        for (int i = 0; i < 48; i++) step($urandom_range(0, 7), 1, 0, 0, 0, $urandom_range(0, 1), 0);
        step(0, 1, 1, 1, 5, 0, 0);
        settle(); chk("pc_35", 16'(pc), 16'h0035);
        step(0, 1, 1, 1, 7, 0, 0);
        settle(); chk("pc_37", 16'(pc), 16'h0037);

        // Halt suppresses same-edge writes and freezes everything.
        for (int i = 0; i < 50; i++) rand_step(0);
        settle();
        saved_pc = int'(pc); saved_instr = int'(instr); saved_ret = int'(retired);
        step(1, 1, 0, 0, 0, 1, 1);
        settle();
        chk("halt_state", 16'(state), 16'h0005);
        chk("halt_flag", 16'(halted), 16'h0001);
        chk("halt_pc", 16'(pc), 16'(saved_pc));
        chk("halt_instr", 16'(instr), 16'(saved_instr));
        chk("halt_ret", retired, 16'(saved_ret));
        for (int i = 0; i < 10; i++) rand_step(1);
        settle();
        chk("frozen_pc", 16'(pc), 16'(saved_pc));
        chk("frozen_state", 16'(state), 16'h0005);
        async_reset("rst_after_halt");

        // Random traffic including halts.
        for (int i = 0; i < 200; i++) rand_step(($urandom_range(0, 19) == 0) ? 1 : 0);
        settle();
        async_reset("rst_mid");

        // Counter saturation.
        for (int i = 0; i < 65534; i++) step($urandom_range(0, 7), 0, 0, 0, 0, 1, 0);
        settle(); chk("ret_fffe", retired, 16'hFFFE);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
        settle(); chk("ret_sat", retired, 16'hFFFF);

        repeat (3) settle();
        chk("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
